// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array edge feeder.
//   DATA_BITS_DEF      default signed operand width per lane
//   feeder_state_e     job sequencing states of systolic_feeder
//   drain_cnt_bits()   width of the DRAIN counter for an N x N array
// ---------------------------------------------------------------------------
package systolic_pkg;

  localparam int DATA_BITS_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } feeder_state_e;

  // The DRAIN counter must be able to represent 2N, hence clog2(2N+1).
  function automatic int drain_cnt_bits(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// ---------------------------------------------------------------------------
// skew_line
// DEPTH-stage shift register that delays one edge lane so that operands
// reach the array diagonally. DEPTH=0 degenerates to a wire.
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset, clears every stage to 0
//   din   in   DATA_BITS lane value
//   dout  out  din delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module skew_line #(
  parameter int DEPTH     = 1,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Clock and reset have no load when the lane is not delayed.
      logic unused_pass;
      assign unused_pass = ^{clk, rst};
      assign dout = din;
    end else begin : g_shift
      logic [DATA_BITS-1:0] stage [DEPTH];

      // Shift register; stage 0 takes the lane input.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < DEPTH; s++) begin
            stage[s] <= {DATA_BITS{1'b0}};
          end
        end else begin
          stage[0] <= din;
          for (int s = 1; s < DEPTH; s++) begin
            stage[s] <= stage[s-1];
          end
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
// Reads A column-by-column and B row-by-row from two synchronous-read
// buffers and drives skewed, zero-padded operand streams into the west and
// north edges of an N x N systolic PE array. Pulses acc_clr before each job
// and pulses done once the far-corner PE has taken its last product.
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   start, k_len job request and inner dimension K, sampled in IDLE
//   busy         high from CLEAR through the done cycle
//   done         one-cycle completion pulse
//   acc_clr      one-cycle accumulator clear for the array
//   rd_en        shared read strobe for the A and B buffers
//   rd_addr      shared read address k
//   a_rdata      A[i][k] in lane i, valid the cycle after rd_en
//   b_rdata      B[k][j] in lane j, valid the cycle after rd_en
//   west_data    lane i feeds the west input of row i
//   north_data   lane j feeds the north input of column j
// All control outputs are registered.
// ---------------------------------------------------------------------------
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N         = 4,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int ADDR_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_BITS-1:0]   k_len,
  output logic                   busy,
  output logic                   done,
  output logic                   acc_clr,
  output logic                   rd_en,
  output logic [ADDR_BITS-1:0]   rd_addr,
  input  logic [N*DATA_BITS-1:0] a_rdata,
  input  logic [N*DATA_BITS-1:0] b_rdata,
  output logic [N*DATA_BITS-1:0] west_data,
  output logic [N*DATA_BITS-1:0] north_data
);

  localparam int CNT_BITS = drain_cnt_bits(N);
  // Last DRAIN count: DRAIN lasts 2N cycles, covering the operand latency
  // plus the diagonal travel to PE(N-1,N-1).
  localparam logic [CNT_BITS-1:0]  DRAIN_LAST = CNT_BITS'(2 * N - 1);
  localparam logic [CNT_BITS-1:0]  CNT_ZERO   = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0]  CNT_ONE    = CNT_BITS'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_ZERO  = {ADDR_BITS{1'b0}};
  localparam logic [ADDR_BITS-1:0] ADDR_ONE   = ADDR_BITS'(1);

  feeder_state_e        state, state_n;
  logic [ADDR_BITS-1:0] k_r, k_n;
  logic [CNT_BITS-1:0]  cnt_r, cnt_n;
  logic [ADDR_BITS-1:0] rd_addr_n;
  logic                 rd_en_n, acc_clr_n, done_n, busy_n;
  logic                 rd_valid;

  // State, job registers and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      k_r      <= ADDR_ZERO;
      cnt_r    <= CNT_ZERO;
      rd_addr  <= ADDR_ZERO;
      rd_en    <= 1'b0;
      acc_clr  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      k_r      <= k_n;
      cnt_r    <= cnt_n;
      rd_addr  <= rd_addr_n;
      rd_en    <= rd_en_n;
      acc_clr  <= acc_clr_n;
      done     <= done_n;
      busy     <= busy_n;
      rd_valid <= rd_en;
    end
  end

  // Next state and the control outputs for the next cycle. Outputs are
  // computed one cycle ahead so that they appear registered in the state
  // they belong to.
  always_comb begin
    state_n   = state;
    k_n       = k_r;
    cnt_n     = cnt_r;
    rd_addr_n = rd_addr;
    rd_en_n   = 1'b0;
    acc_clr_n = 1'b0;
    done_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n   = ST_CLEAR;
          k_n       = k_len;
          acc_clr_n = 1'b1;
          rd_en_n   = (k_len != ADDR_ZERO);
          rd_addr_n = ADDR_ZERO;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        cnt_n = CNT_ZERO;
        if (k_r == ADDR_ZERO) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end else if (k_r == ADDR_ONE) begin
          state_n = ST_DRAIN;
        end else begin
          state_n   = ST_STREAM;
          rd_en_n   = 1'b1;
          rd_addr_n = rd_addr + ADDR_ONE;
        end
      end
      ST_STREAM: begin
        // rd_addr currently on the port is the one being issued this cycle.
        if (rd_addr == (k_r - ADDR_ONE)) begin
          state_n = ST_DRAIN;
        end else begin
          rd_en_n   = 1'b1;
          rd_addr_n = rd_addr + ADDR_ONE;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // Lane datapath: zero-inject on invalid cycles, skew by lane index, then
  // one shared output register per edge.
  logic [N*DATA_BITS-1:0] west_skew, north_skew;

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DATA_BITS-1:0] west_in, north_in;

      assign west_in  = rd_valid ? a_rdata[i*DATA_BITS +: DATA_BITS] : {DATA_BITS{1'b0}};
      assign north_in = rd_valid ? b_rdata[i*DATA_BITS +: DATA_BITS] : {DATA_BITS{1'b0}};

      skew_line #(.DEPTH(i), .DATA_BITS(DATA_BITS)) u_west_skew (
        .clk  (clk),
        .rst  (rst),
        .din  (west_in),
        .dout (west_skew[i*DATA_BITS +: DATA_BITS])
      );

      skew_line #(.DEPTH(i), .DATA_BITS(DATA_BITS)) u_north_skew (
        .clk  (clk),
        .rst  (rst),
        .din  (north_in),
        .dout (north_skew[i*DATA_BITS +: DATA_BITS])
      );
    end
  endgenerate

  // Edge output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      west_data  <= {(N*DATA_BITS){1'b0}};
      north_data <= {(N*DATA_BITS){1'b0}};
    end else begin
      west_data  <= west_skew;
      north_data <= north_skew;
    end
  end

endmodule
